gte_cop2_bridge: RTL and testbench
==================================

Name: gte_cop2_bridge

Overview:
- CPU-side initiator for the GTE register/command port. It queues COP2 requests from the CPU pipeline: register writes (MTC2/CTC2/LWC2), register reads (MFC2/CFC2/SWC2) and GTE commands.
- It drives the GTE's regID / write / data / instruction / run inputs and honours the GTE's executing flag.
- Read data goes back to the CPU. Sits between the CPU COP2 stage and the GTE engine.

Parameters:
- FIFO_DEPTH, 2, request queue entries (power of two, 2..8).
- CNT_W, 8, width of the saturating command-duration counter.

Ports:
- i_clk  in  1  clock.
- i_nRst  in  1  asynchronous active-low reset (0 = reset).
- i_reqValid  in  1  CPU request strobe.
- o_reqReady  out  1  queue can accept a request this cycle.
- i_reqOp  in  2  request type: 0 = write, 1 = read, 2 = command, 3 = reserved (dropped).
- i_reqReg  in  6  register index: 0-31 data, 32-63 control.
- i_reqData  in  32  write value.
- i_reqCmd  in  25  command word.
- o_rdValid  out  1  one-cycle pulse, read result valid.
- o_rdData  out  32  read result, held until the next read.
- o_busy  out  1  queue non-empty, or FSM not IDLE, or i_gteExecuting.
- o_gteRegID  out  6  register index to GTE.
- o_gteWrite  out  1  write strobe to GTE.
- o_gteData  out  32  write value to GTE.
- o_gteInstr  out  25  instruction to GTE.
- o_gteRun  out  1  instruction-valid strobe to GTE.
- i_gteData  in  32  GTE read value; combinational from o_gteRegID, zero latency.
- i_gteExecuting  in  1  GTE busy.
- o_lastCmdCycles  out  CNT_W  executing-cycle count of the last completed command.

Behaviour:
- Reset: every output and state register goes to 0 and the FSM goes to IDLE. Exception: o_reqReady = 1 after reset (queue empty). Asserting reset mid-operation discards the queue and any in-flight strobe.
- Queue: push when i_reqValid & o_reqReady. o_reqReady = !full. Pop happens only in IDLE on issue. Push and pop in the same cycle are legal when full. Read and write pointers wrap modulo FIFO_DEPTH. Op 3 is pushed, then popped and discarded without touching GTE outputs.
- Issue condition (IDLE): queue non-empty & !i_gteExecuting. The GTE ignores writes while executing, so writes are also held back.
- On issue, the FSM registers the GTE-side values:
  - o_gteRegID from the entry, for every op.
  - o_gteData, for writes.
  - o_gteInstr, for commands.
- FSM states: IDLE, WRITE, READ, RUN, GUARD, WAIT_DONE.
  - IDLE -> WRITE/READ/RUN on issue.
  - WRITE: o_gteWrite = 1 for exactly this cycle -> IDLE.
  - READ: sample i_gteData at the end of the cycle into o_rdData. o_rdValid = 1 the following cycle (1-cycle pulse) -> IDLE.
  - RUN: o_gteRun = 1 for exactly this cycle -> GUARD.
  - GUARD: one cycle, ignore i_gteExecuting, because the GTE raises it the cycle after run. Clear the counter -> WAIT_DONE.
  - WAIT_DONE: count +1 (saturating at 2^CNT_W-1) each cycle i_gteExecuting = 1. On i_gteExecuting = 0, copy the count to o_lastCmdCycles -> IDLE.
  - If executing never rises (fast-GTE zero-cycle case), WAIT_DONE exits on its first cycle and o_lastCmdCycles = 0.
- All GTE-side outputs are registered, with no combinational path from i_req*.
- o_gteRegID/o_gteData/o_gteInstr hold their values after the strobe until the next issue.
- Ordering: strict FIFO. A read queued behind a command returns post-command data.
- Minimum latencies:
  - Write: push at cycle N, strobe at N+2.
  - Read: push at N, o_rdValid at N+3.
  - Command: push at N, o_gteRun at N+2.

Decomposition:
- Shared package (gte_cop2_pkg): op-code enum (OP_WRITE, OP_READ, OP_CMD, OP_RSVD), FSM state enum, packed request struct {op, reg, data, cmd}.
- Sub-module gte_cop2_fifo: parameterised synchronous FIFO of request structs, async-reset pointers, full/empty flags.

Test Plan:
- Write reg 33 = 0x12345678 with executing = 0 -> o_gteRegID = 33 and o_gteWrite pulses once, 2 cycles after push, with o_gteData = 0x12345678.
- Read reg 7 while the model drives i_gteData = 0xCAFEF00D for regID 7 -> one o_rdValid pulse 3 cycles after push, o_rdData = 0xCAFEF00D.
- Command 0x0000001 while the model holds executing for 15 cycles after run -> o_gteRun pulses once, o_busy = 1 throughout, o_lastCmdCycles = 15. A write queued behind it issues only after executing = 0.
- Push 3 requests back-to-back with FIFO_DEPTH = 2 while executing = 1 -> o_reqReady = 0 after 2 pushes. The 3rd is accepted the cycle after the first pop. Issue order is preserved.
- Op 3 between two writes -> no GTE strobe for it; both writes appear in order.
- Assert i_nRst = 0 during WAIT_DONE with 2 entries queued -> immediate: all outputs 0, o_reqReady = 1, no further strobes after release.

Source files
------------

// File: rtl/gte_cop2_pkg.sv
// Shared types for the CPU-side GTE COP2 bridge: request op-codes, bridge
// FSM states and the packed request word held in the request queue.
package gte_cop2_pkg;

  localparam int unsigned REG_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 25;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_CMD   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_RUN       = 3'd3,
    ST_GUARD     = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [REG_W-1:0]  regIdx;
    logic [DATA_W-1:0] data;
    logic [CMD_W-1:0]  cmd;
  } req_t;

endpackage

// File: rtl/gte_cop2_fifo.sv
// Synchronous request queue. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module gte_cop2_fifo
  import gte_cop2_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_nRst,
  input  logic i_push,
  input  req_t i_pushData,
  input  logic i_pop,
  output req_t o_popData,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned   PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  req_t           mem_q [DEPTH];
  logic [PTR_W:0] wrPtr_q, wrPtr_d;
  logic [PTR_W:0] rdPtr_q, rdPtr_d;
  logic           doPush, doPop;

  assign o_empty   = (wrPtr_q == rdPtr_q);
  assign o_full    = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign doPop     = i_pop && !o_empty;
  assign doPush    = i_push && (!o_full || doPop);
  assign o_popData = mem_q[rdPtr_q[PTR_W-1:0]];

  // Pointer advance; both may move in the same cycle.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
    if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
  end

  // Pointer registers.
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      mem_q <= '{default: '0};
    end else if (doPush) begin
      mem_q[wrPtr_q[PTR_W-1:0]] <= i_pushData;
    end
  end

endmodule

// File: rtl/gte_cop2_bridge.sv
// CPU-side initiator for the GTE register/command port. Queues COP2 requests
// and replays them to the GTE one at a time, holding everything back while the
// GTE reports it is executing. All GTE-facing signals come straight from flops.
module gte_cop2_bridge
  import gte_cop2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_nRst,
  input  logic              i_reqValid,
  output logic              o_reqReady,
  input  logic [1:0]        i_reqOp,
  input  logic [REG_W-1:0]  i_reqReg,
  input  logic [DATA_W-1:0] i_reqData,
  input  logic [CMD_W-1:0]  i_reqCmd,
  output logic              o_rdValid,
  output logic [DATA_W-1:0] o_rdData,
  output logic              o_busy,
  output logic [REG_W-1:0]  o_gteRegID,
  output logic              o_gteWrite,
  output logic [DATA_W-1:0] o_gteData,
  output logic [CMD_W-1:0]  o_gteInstr,
  output logic              o_gteRun,
  input  logic [DATA_W-1:0] i_gteData,
  input  logic              i_gteExecuting,
  output logic [CNT_W-1:0]  o_lastCmdCycles
);

  req_t              pushReq, headReq;
  logic              fifoFull, fifoEmpty;
  logic              issue;

  state_e            state_q, state_d;
  logic [REG_W-1:0]  regId_q, regId_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic [CMD_W-1:0]  instr_q, instr_d;
  logic              write_q, write_d;
  logic              run_q, run_d;
  logic              rdValid_q, rdValid_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_q, last_d;

  assign pushReq = '{op: op_e'(i_reqOp), regIdx: i_reqReg, data: i_reqData, cmd: i_reqCmd};

  // Reserved ops are popped through the same issue path but leave the GTE
  // outputs untouched, so the queue never stalls on them.
  assign issue = (state_q == ST_IDLE) && !fifoEmpty && !i_gteExecuting;

  gte_cop2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_nRst    (i_nRst),
    .i_push    (i_reqValid && o_reqReady),
    .i_pushData(pushReq),
    .i_pop     (issue),
    .o_popData (headReq),
    .o_full    (fifoFull),
    .o_empty   (fifoEmpty)
  );

  // Next-state and registered-output decode; strobes default low each cycle.
  always_comb begin
    state_d   = state_q;
    regId_d   = regId_q;
    wrData_d  = wrData_q;
    instr_d   = instr_q;
    write_d   = 1'b0;
    run_d     = 1'b0;
    rdValid_d = 1'b0;
    rdData_d  = rdData_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) begin
          unique case (headReq.op)
            OP_WRITE: begin
              regId_d  = headReq.regIdx;
              wrData_d = headReq.data;
              write_d  = 1'b1;
              state_d  = ST_WRITE;
            end
            OP_READ: begin
              regId_d = headReq.regIdx;
              state_d = ST_READ;
            end
            OP_CMD: begin
              regId_d = headReq.regIdx;
              instr_d = headReq.cmd;
              run_d   = 1'b1;
              state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        rdData_d  = i_gteData;
        rdValid_d = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_RUN: state_d = ST_GUARD;
      ST_GUARD: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_gteExecuting) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
          last_d  = cnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q   <= ST_IDLE;
      regId_q   <= '0;
      wrData_q  <= '0;
      instr_q   <= '0;
      write_q   <= 1'b0;
      run_q     <= 1'b0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      regId_q   <= regId_d;
      wrData_q  <= wrData_d;
      instr_q   <= instr_d;
      write_q   <= write_d;
      run_q     <= run_d;
      rdValid_q <= rdValid_d;
      rdData_q  <= rdData_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign o_reqReady      = !fifoFull;
  assign o_busy          = !fifoEmpty || (state_q != ST_IDLE) || i_gteExecuting;
  assign o_gteRegID      = regId_q;
  assign o_gteWrite      = write_q;
  assign o_gteData       = wrData_q;
  assign o_gteInstr      = instr_q;
  assign o_gteRun        = run_q;
  assign o_rdValid       = rdValid_q;
  assign o_rdData        = rdData_q;
  assign o_lastCmdCycles = last_q;

endmodule

// File: tb/tb_gte_cop2_bridge.sv
// Scoreboard bench for gte_cop2_bridge: a behavioural GTE (register file plus
// command-duration model) sits on the GTE side; every accepted request pushes
// its expected GTE-side effect into a queue that an independent monitor drains.
module tb_gte_cop2_bridge;
  import gte_cop2_pkg::*;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 8;

  logic              i_clk = 1'b0;
  logic              i_nRst;
  logic              i_reqValid;
  logic              o_reqReady;
  logic [1:0]        i_reqOp;
  logic [5:0]        i_reqReg;
  logic [31:0]       i_reqData;
  logic [24:0]       i_reqCmd;
  logic              o_rdValid;
  logic [31:0]       o_rdData;
  logic              o_busy;
  logic [5:0]        o_gteRegID;
  logic              o_gteWrite;
  logic [31:0]       o_gteData;
  logic [24:0]       o_gteInstr;
  logic              o_gteRun;
  logic [31:0]       i_gteData;
  logic              i_gteExecuting;
  logic [CNT_W-1:0]  o_lastCmdCycles;

  typedef struct {
    logic [5:0]  r;
    logic [31:0] d;
    logic [24:0] c;
    int          L;
    int          at;
  } exp_t;

  exp_t        wr_exp[$];
  exp_t        rd_exp[$];
  exp_t        run_exp[$];
  int          lat_fifo[$];
  logic [31:0] ref_regs [64];
  logic [31:0] gte_regs [64];
  int          checks  = 0;
  int          errors  = 0;
  int          strobes = 0;
  int          cyc     = 0;
  logic        exec_model = 1'b0;
  logic        exec_force = 1'b0;
  bit          last_pend  = 1'b0;
  int          last_at, last_exp;

  gte_cop2_bridge #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk          (i_clk),
    .i_nRst         (i_nRst),
    .i_reqValid     (i_reqValid),
    .o_reqReady     (o_reqReady),
    .i_reqOp        (i_reqOp),
    .i_reqReg       (i_reqReg),
    .i_reqData      (i_reqData),
    .i_reqCmd       (i_reqCmd),
    .o_rdValid      (o_rdValid),
    .o_rdData       (o_rdData),
    .o_busy         (o_busy),
    .o_gteRegID     (o_gteRegID),
    .o_gteWrite     (o_gteWrite),
    .o_gteData      (o_gteData),
    .o_gteInstr     (o_gteInstr),
    .o_gteRun       (o_gteRun),
    .i_gteData      (i_gteData),
    .i_gteExecuting (i_gteExecuting),
    .o_lastCmdCycles(o_lastCmdCycles)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // The GTE is reset together with the bridge, and reads are combinational.
  assign i_gteData      = gte_regs[o_gteRegID];
  assign i_gteExecuting = (exec_model | exec_force) & i_nRst;

  // Abstract effect of a GTE command: it overwrites one register.
  function automatic logic [31:0] cmd_effect(input logic [24:0] c);
    return {7'd0, c} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  // Reference model: applies the request in program order at acceptance time.
  task automatic record(input logic [1:0] op, input logic [5:0] r, input logic [31:0] d,
                        input logic [24:0] c, input int L, input int k, input bit chk);
    exp_t e;
    e.r = r; e.d = d; e.c = c; e.L = L; e.at = -1;
    case (op)
      2'd0: begin
        ref_regs[r] = d;
        if (chk) e.at = k + 2;
        wr_exp.push_back(e);
      end
      2'd1: begin
        e.d = ref_regs[r];
        if (chk) e.at = k + 3;
        rd_exp.push_back(e);
      end
      2'd2: begin
        if (chk) e.at = k + 2;
        run_exp.push_back(e);
        lat_fifo.push_back(L);
        ref_regs[c[5:0]] = cmd_effect(c);
      end
      default: ;
    endcase
  endtask

  task automatic push(input logic [1:0] op, input logic [5:0] r, input logic [31:0] d,
                      input logic [24:0] c, input int L, input bit chk);
    int waited = 0;
    i_reqValid = 1'b1;
    i_reqOp    = op;
    i_reqReg   = r;
    i_reqData  = d;
    i_reqCmd   = c;
    while (!o_reqReady && waited < 300) begin
      @(posedge i_clk); #1;
      waited++;
    end
    if (!o_reqReady) begin
      flag("push_timeout", "ready stayed 0 for 300 cycles, expected 1");
    end else begin
      record(op, r, d, c, L, cyc, chk);
      @(posedge i_clk); #1;
    end
    i_reqValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((o_busy || wr_exp.size() != 0 || rd_exp.size() != 0 ||
            run_exp.size() != 0 || last_pend) && n < 3000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 3000) flag("idle_timeout", "busy or outstanding expectations after 3000 cycles, expected idle");
  endtask

  // Behavioural GTE: latches writes, runs commands for the requested length.
  initial begin
    bit          act = 1'b0;
    int          st = 0, en = 0, L;
    logic [24:0] gc = '0;
    forever begin
      @(posedge i_clk); #1;
      if (!i_nRst) begin
        act        = 1'b0;
        exec_model = 1'b0;
      end else begin
        if (o_gteWrite) gte_regs[o_gteRegID] = o_gteData;
        if (act && cyc == en) begin
          gte_regs[gc[5:0]] = cmd_effect(gc);
          exec_model = 1'b0;
          act        = 1'b0;
        end else if (act && cyc >= st) begin
          exec_model = 1'b1;
        end
        if (o_gteRun) begin
          L = 0;
          if (lat_fifo.size() != 0) L = lat_fifo.pop_front();
          st  = cyc + 2;
          en  = cyc + 2 + L;
          gc  = o_gteInstr;
          act = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk); #1;
      if (!i_nRst) begin
        last_pend = 1'b0;
      end else begin
        if (o_gteWrite) begin
          strobes++;
          if (wr_exp.size() == 0) begin
            flag("wr_unexpected", "write strobe seen, expected none");
          end else begin
            e = wr_exp.pop_front();
            check("wr_regid", 32'(o_gteRegID), 32'(e.r));
            check("wr_data", o_gteData, e.d);
            check("wr_exec_low", 32'(i_gteExecuting), 32'd0);
            if (e.at >= 0) check("wr_latency", cyc, e.at);
          end
        end
        if (o_rdValid) begin
          if (rd_exp.size() == 0) begin
            flag("rd_unexpected", "read valid seen, expected none");
          end else begin
            e = rd_exp.pop_front();
            check("rd_data", o_rdData, e.d);
            if (e.at >= 0) check("rd_latency", cyc, e.at);
          end
        end
        if (o_gteRun) begin
          strobes++;
          if (run_exp.size() == 0) begin
            flag("run_unexpected", "run strobe seen, expected none");
          end else begin
            e = run_exp.pop_front();
            check("run_instr", 32'(o_gteInstr), 32'(e.c));
            if (e.at >= 0) check("run_latency", cyc, e.at);
            last_pend = 1'b1;
            last_at   = cyc + 3 + e.L;
            last_exp  = e.L;
          end
        end else if (last_pend) begin
          if (cyc == last_at) begin
            check("last_cmd_cycles", 32'(o_lastCmdCycles), last_exp);
            last_pend = 1'b0;
          end else begin
            check("busy_during_cmd", 32'(o_busy), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int s0, rel, acc, sel, gap;
    logic [1:0] op;
    i_nRst     = 1'b0;
    i_reqValid = 1'b0;
    i_reqOp    = '0;
    i_reqReg   = '0;
    i_reqData  = '0;
    i_reqCmd   = '0;
    for (int i = 0; i < 64; i++) begin
      gte_regs[i] = 32'h1000_0000 + i;
      ref_regs[i] = 32'h1000_0000 + i;
    end

    // Reset state.
    #2;
    check("rst_ready", 32'(o_reqReady), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_write", 32'(o_gteWrite), 32'd0);
    check("rst_run", 32'(o_gteRun), 32'd0);
    check("rst_rdvalid", 32'(o_rdValid), 32'd0);
    check("rst_regid", 32'(o_gteRegID), 32'd0);
    check("rst_last", 32'(o_lastCmdCycles), 32'd0);
    repeat (3) @(negedge i_clk);
    i_nRst = 1'b1;
    @(posedge i_clk); #1;

    // Single write to a control register.
    push(2'd0, 6'd33, 32'h1234_5678, 25'd0, 0, 1'b1);
    wait_idle();
    check("wr_regid_hold", 32'(o_gteRegID), 32'd33);
    check("wr_data_hold", o_gteData, 32'h1234_5678);

    // Single read.
    gte_regs[7] = 32'hCAFE_F00D;
    ref_regs[7] = 32'hCAFE_F00D;
    push(2'd1, 6'd7, 32'd0, 25'd0, 0, 1'b1);
    wait_idle();
    check("rd_data_hold", o_rdData, 32'hCAFE_F00D);

    // Command lasting 15 executing cycles, with a write queued behind it.
    push(2'd2, 6'd0, 32'd0, 25'h000_0001, 15, 1'b1);
    push(2'd0, 6'd12, 32'hA5A5_0001, 25'd0, 0, 1'b0);
    push(2'd1, 6'd1, 32'd0, 25'd0, 0, 1'b0);
    wait_idle();

    // Queue fills while the GTE is busy; third request waits for the first pop.
    exec_force = 1'b1;
    push(2'd0, 6'd20, 32'h0000_1111, 25'd0, 0, 1'b0);
    push(2'd0, 6'd21, 32'h0000_2222, 25'd0, 0, 1'b0);
    check("ready_when_full", 32'(o_reqReady), 32'd0);
    i_reqValid = 1'b1;
    i_reqOp    = 2'd0;
    i_reqReg   = 6'd22;
    i_reqData  = 32'h0000_3333;
    rel = -1;
    acc = -1;
    for (int n = 0; n < 20 && acc < 0; n++) begin
      if (n == 3) begin
        exec_force = 1'b0;
        rel        = cyc;
      end
      if (o_reqReady) acc = cyc;
      else begin
        @(posedge i_clk); #1;
      end
    end
    if (acc < 0) begin
      flag("third_accept", "third request never accepted, expected acceptance after first pop");
    end else begin
      record(2'd0, 6'd22, 32'h0000_3333, 25'd0, 0, acc, 1'b0);
      check("third_accept_cycle", acc, rel + 1);
      @(posedge i_clk); #1;
    end
    i_reqValid = 1'b0;
    exec_force = 1'b0;
    wait_idle();

    // Reserved op between two writes.
    s0 = strobes;
    push(2'd0, 6'd40, 32'hBEEF_0001, 25'd0, 0, 1'b1);
    push(2'd3, 6'd41, 32'hDEAD_DEAD, 25'h1AB_CDEF, 0, 1'b0);
    push(2'd0, 6'd42, 32'hBEEF_0002, 25'd0, 0, 1'b0);
    wait_idle();
    check("rsvd_strobe_count", strobes - s0, 32'd2);
    check("rsvd_reg41_untouched", gte_regs[41], ref_regs[41]);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      op = 2'd0;
      else if (sel < 7) op = 2'd1;
      else if (sel < 9) op = 2'd2;
      else              op = 2'd3;
      push(op, 6'($urandom_range(0, 63)), $urandom, 25'($urandom),
           $urandom_range(0, 12), 1'b0);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge i_clk); #1;
      end
    end
    wait_idle();
    check("rand_final_regs_sample", gte_regs[5], ref_regs[5]);

    // Reset while a long command is executing with two entries queued.
    push(2'd2, 6'd0, 32'd0, 25'h000_0045, 40, 1'b0);
    push(2'd0, 6'd50, 32'h5050_5050, 25'd0, 0, 1'b0);
    push(2'd0, 6'd51, 32'h5151_5151, 25'd0, 0, 1'b0);
    repeat (8) begin
      @(posedge i_clk); #1;
    end
    check("pre_reset_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    i_nRst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(o_reqReady), 32'd1);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_write", 32'(o_gteWrite), 32'd0);
    check("mid_rst_run", 32'(o_gteRun), 32'd0);
    check("mid_rst_rdvalid", 32'(o_rdValid), 32'd0);
    check("mid_rst_rddata", o_rdData, 32'd0);
    check("mid_rst_regid", 32'(o_gteRegID), 32'd0);
    check("mid_rst_data", o_gteData, 32'd0);
    check("mid_rst_instr", 32'(o_gteInstr), 32'd0);
    check("mid_rst_last", 32'(o_lastCmdCycles), 32'd0);
    wr_exp.delete();
    rd_exp.delete();
    run_exp.delete();
    lat_fifo.delete();
    s0 = strobes;
    repeat (3) @(negedge i_clk);
    i_nRst = 1'b1;
    for (int i = 0; i < 64; i++) ref_regs[i] = gte_regs[i];
    repeat (30) begin
      @(posedge i_clk); #1;
    end
    check("post_rst_strobes", strobes - s0, 32'd0);
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_ready", 32'(o_reqReady), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
